// File: rtl/spi_master_arb_pkg.sv
// Shared SPI definitions: FSM state encoding, SPI mode constants and the
// round-robin pick used by the two-requester arbiter.
package spi_master_arb_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_LOW,
    ST_HIGH,
    ST_GAP
  } state_e;

  // Mode 0: sclk idles low, data sampled on the rising sclk edge.
  localparam logic        SPI_CPOL = 1'b0;
  localparam int unsigned SPI_BITS = 8;

  // Index to grant; on contention the requester not granted last wins.
  function automatic logic rr_pick(input logic [1:0] req, input logic last);
    if (req == 2'b11) return ~last;
    return req[1];
  endfunction

endpackage

// File: rtl/spi_master_arb_if.sv
// Requester handshake and SPI pin bundle; master is the arbiter side.
interface spi_master_arb_if;
  logic [1:0] req;
  logic [7:0] tx_data0;
  logic [7:0] tx_data1;
  logic [1:0] gnt;
  logic [1:0] tx_ack;
  logic [7:0] rx_data;
  logic [1:0] rx_valid;
  logic       ss;
  logic       sclk;
  logic       mosi;
  logic       miso;

  modport master (
    input  req, tx_data0, tx_data1, miso,
    output gnt, tx_ack, rx_data, rx_valid, ss, sclk, mosi
  );

  modport slave (
    output req, tx_data0, tx_data1, miso,
    input  gnt, tx_ack, rx_data, rx_valid, ss, sclk, mosi
  );
endinterface

// File: rtl/spi_shift8.sv
// Byte shifter plus half-period counter: MSB-first tx shift on leaving HIGH,
// miso shifted in on the LOW->HIGH edge; no backpressure, paced by the FSM.
module spi_shift8
  import spi_master_arb_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       load_i,
  input  logic [7:0] load_dat_i,
  input  logic       run_i,
  input  logic       low_i,
  input  logic       high_i,
  input  logic       miso_i,
  output logic       mosi_o,
  output logic       half_done_o,
  output logic       last_bit_o,
  output logic [7:0] rx_byte_o
);

  localparam logic [7:0] CNT_LAST = 8'(DIV - 1);
  localparam logic [2:0] BIT_LAST = 3'(SPI_BITS - 1);

  logic [7:0] cnt_q, cnt_d;
  logic [7:0] tx_q, tx_d;
  logic [7:0] rx_q, rx_d;
  logic [2:0] bit_q, bit_d;

  assign half_done_o = (cnt_q == CNT_LAST);
  assign last_bit_o  = (bit_q == BIT_LAST);
  assign mosi_o      = tx_q[7];
  assign rx_byte_o   = rx_q;

  always_comb begin
    cnt_d = (run_i && !half_done_o) ? cnt_q + 8'd1 : 8'd0;
    tx_d  = tx_q;
    rx_d  = rx_q;
    bit_d = bit_q;
    if (load_i) begin
      tx_d  = load_dat_i;
      bit_d = '0;
    end else if (low_i && half_done_o) begin
      rx_d = {rx_q[6:0], miso_i};
    end else if (high_i && half_done_o) begin
      tx_d  = {tx_q[6:0], 1'b0};
      bit_d = bit_q + 3'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt_q <= '0;
      tx_q  <= '0;
      rx_q  <= '0;
      bit_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      tx_q  <= tx_d;
      rx_q  <= rx_d;
      bit_q <= bit_d;
    end
  end

endmodule

// File: rtl/spi_master_arb.sv
// Two-requester round-robin SPI mode-0 master: 1+16*DIV cycles per byte, bursts
// continue while req stays high; a losing requester simply waits with req held.
module spi_master_arb
  import spi_master_arb_pkg::*;
#(
  parameter int unsigned DIV = 2
) (
  input  logic              clk,
  input  logic              reset,
  spi_master_arb_if.master  bus
);

  state_e     state_q, state_d;
  logic [1:0] gnt_q, gnt_d;
  logic [1:0] tx_ack_q, tx_ack_d;
  logic [1:0] rx_valid_q, rx_valid_d;
  logic [7:0] rx_data_q, rx_data_d;
  logic       last_q, last_d;

  logic       pick;
  logic [7:0] tx_sel;
  logic       half_done;
  logic       last_bit;
  logic       sh_mosi;
  logic [7:0] rx_byte;

  assign pick   = rr_pick(bus.req, last_q);
  assign tx_sel = gnt_q[1] ? bus.tx_data1 : bus.tx_data0;

  spi_shift8 #(.DIV(DIV)) u_shift (
    .clk         (clk),
    .reset       (reset),
    .load_i      (state_q == ST_LOAD),
    .load_dat_i  (tx_sel),
    .run_i       (state_q inside {ST_LOW, ST_HIGH, ST_GAP}),
    .low_i       (state_q == ST_LOW),
    .high_i      (state_q == ST_HIGH),
    .miso_i      (bus.miso),
    .mosi_o      (sh_mosi),
    .half_done_o (half_done),
    .last_bit_o  (last_bit),
    .rx_byte_o   (rx_byte)
  );

  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    last_d     = last_q;
    tx_ack_d   = '0;
    rx_valid_d = '0;
    rx_data_d  = rx_data_q;
    case (state_q)
      ST_IDLE: begin
        if (bus.req != 2'b00) begin
          state_d = ST_LOAD;
          gnt_d   = pick ? 2'b10 : 2'b01;
          last_d  = pick;
        end
      end
      ST_LOAD: begin
        state_d  = ST_LOW;
        tx_ack_d = gnt_q;
      end
      ST_LOW: begin
        if (half_done) state_d = ST_HIGH;
      end
      ST_HIGH: begin
        if (half_done) begin
          if (last_bit) begin
            rx_data_d  = rx_byte;
            rx_valid_d = gnt_q;
            // Burst continues only for the owner; the other side waits for GAP.
            if ((bus.req & gnt_q) != 2'b00) begin
              state_d = ST_LOAD;
            end else begin
              state_d = ST_GAP;
              gnt_d   = '0;
            end
          end else begin
            state_d = ST_LOW;
          end
        end
      end
      ST_GAP: begin
        if (half_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      gnt_q      <= '0;
      tx_ack_q   <= '0;
      rx_valid_q <= '0;
      rx_data_q  <= '0;
      last_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      tx_ack_q   <= tx_ack_d;
      rx_valid_q <= rx_valid_d;
      rx_data_q  <= rx_data_d;
      last_q     <= last_d;
    end
  end

  assign bus.gnt      = gnt_q;
  assign bus.tx_ack   = tx_ack_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.ss       = state_q inside {ST_LOAD, ST_LOW, ST_HIGH};
  assign bus.sclk     = (state_q == ST_HIGH) ^ SPI_CPOL;
  assign bus.mosi     = (state_q == ST_LOAD) ? tx_sel[7] :
                        (state_q inside {ST_LOW, ST_HIGH}) ? sh_mosi : 1'b0;

endmodule

// File: tb/tb_spi_master_arb.sv
// Scoreboard bench: DIV=2 instance for arbitration/burst/reset cases, DIV=1
// instance for the fast-clock bit-sequence case.
module tb_spi_master_arb;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  logic       req0 = 1'b0, req1 = 1'b0;
  logic [7:0] tx0 = 8'h00, tx1 = 8'h00;
  logic       miso_inv = 1'b0;
  logic       d1_req = 1'b0;
  logic [7:0] d1_tx = 8'h00;

  spi_master_arb_if bus2();
  spi_master_arb_if bus1();

  assign bus2.req      = {req1, req0};
  assign bus2.tx_data0 = tx0;
  assign bus2.tx_data1 = tx1;
  assign bus2.miso     = miso_inv ? ~bus2.mosi : bus2.mosi;

  assign bus1.req      = {1'b0, d1_req};
  assign bus1.tx_data0 = d1_tx;
  assign bus1.tx_data1 = 8'h00;
  assign bus1.miso     = 1'b1;

  spi_master_arb #(.DIV(2)) u_dut  (.clk(clk), .reset(reset), .bus(bus2));
  spi_master_arb #(.DIV(1)) u_dut1 (.clk(clk), .reset(reset), .bus(bus1));

  int n_checks = 0;
  int n_errors = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Monitor state
  int         cyc = 0, ack_cyc = 0;
  int         ss_run = 0, ss_last = 0, lo_run = 0, lo_last = 0, rx_seen = 0;
  logic [1:0] gnt_prev = 2'b00;
  logic [1:0] gnt_log[$];
  logic [7:0] exp0[$];
  logic [7:0] exp1[$];
  int         c1_rise = 0, c1_last_rise = 0, c1_pmin = 999, c1_pmax = 0, c1_p = 0;
  int         ss1_run = 0, ss1_last = 0;
  logic [7:0] mosi_seq = 8'h00;
  logic       sclk1_prev = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (bus2.tx_ack != 2'b00) ack_cyc = cyc;
    if (bus2.ss) begin
      if (lo_run != 0) lo_last = lo_run;
      lo_run = 0;
      ss_run++;
    end else begin
      if (ss_run != 0) ss_last = ss_run;
      ss_run = 0;
      lo_run++;
    end
    if (bus2.gnt != 2'b00 && bus2.gnt != gnt_prev) gnt_log.push_back(bus2.gnt);
    gnt_prev = bus2.gnt;
    if (bus2.rx_valid != 2'b00) begin
      rx_seen++;
      chk("ack_to_rx_cycles", cyc - ack_cyc, 32);
      chk("ack_rx_overlap", bus2.tx_ack, 2'b00);
      if (bus2.rx_valid == 2'b01) begin
        if (exp0.size() == 0) chk("rx0_unexpected", bus2.rx_valid, 2'b00);
        else chk("rx0_data", bus2.rx_data, exp0.pop_front());
      end else if (bus2.rx_valid == 2'b10) begin
        if (exp1.size() == 0) chk("rx1_unexpected", bus2.rx_valid, 2'b00);
        else chk("rx1_data", bus2.rx_data, exp1.pop_front());
      end else begin
        chk("rx_valid_onehot", bus2.rx_valid, 2'b01);
      end
    end
    // DIV=1 instance: sclk period and mosi value at each rising sclk
    if (bus1.sclk && !sclk1_prev) begin
      c1_rise++;
      mosi_seq = {mosi_seq[6:0], bus1.mosi};
      if (c1_last_rise != 0) begin
        c1_p = cyc - c1_last_rise;
        if (c1_p < c1_pmin) c1_pmin = c1_p;
        if (c1_p > c1_pmax) c1_pmax = c1_p;
      end
      c1_last_rise = cyc;
    end
    sclk1_prev = bus1.sclk;
    if (bus1.ss) ss1_run++;
    else begin
      if (ss1_run != 0) ss1_last = ss1_run;
      ss1_run = 0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int n, input logic v);
    if (n == 0) req0 = v; else req1 = v;
  endtask

  task automatic set_tx(input int n, input logic [7:0] d);
    if (n == 0) tx0 = d; else tx1 = d;
  endtask

  task automatic push_exp(input int n, input logic [7:0] d);
    logic [7:0] e;
    e = miso_inv ? ~d : d;
    if (n == 0) exp0.push_back(e); else exp1.push_back(e);
  endtask

  task automatic wait_ack(input int n);
    int t;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus2.tx_ack[n] !== 1'b1 && t < 400);
    if (t >= 400) chk("ack_timeout", bus2.tx_ack[n], 1'b1);
  endtask

  task automatic drive_req(input int n, input int nb, input logic [7:0] b0,
                           input logic [7:0] b1, input logic [7:0] b2);
    logic [7:0] bs [3];
    bs[0] = b0; bs[1] = b1; bs[2] = b2;
    set_tx(n, bs[0]);
    push_exp(n, bs[0]);
    set_req(n, 1'b1);
    for (int k = 0; k < nb; k++) begin
      wait_ack(n);
      tick();
      if (k + 1 < nb) begin
        set_tx(n, bs[k+1]);
        push_exp(n, bs[k+1]);
      end else begin
        set_req(n, 1'b0);
      end
    end
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    while ((exp0.size() + exp1.size() != 0 || bus2.ss || bus2.gnt != 2'b00) && t < 2000) begin
      @(negedge clk);
      t++;
    end
    if (t >= 2000) chk("idle_timeout", exp0.size() + exp1.size(), 0);
    repeat (4) @(negedge clk);
    tick();
  endtask

  task automatic chk_grants(input string tag, input int base);
    chk({tag, "_len"}, gnt_log.size() - base, 2);
    if (gnt_log.size() >= base + 2) begin
      chk({tag, "_first"}, gnt_log[base], 2'b01);
      chk({tag, "_second"}, gnt_log[base+1], 2'b10);
    end
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: bench did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t;
    int base;
    int rx_before;

    repeat (2) @(negedge clk);
    chk("rst_ss", bus2.ss, 1'b0);
    chk("rst_sclk", bus2.sclk, 1'b0);
    chk("rst_mosi", bus2.mosi, 1'b0);
    chk("rst_gnt", bus2.gnt, 2'b00);
    chk("rst_tx_ack", bus2.tx_ack, 2'b00);
    chk("rst_rx_valid", bus2.rx_valid, 2'b00);
    chk("rst_rx_data", bus2.rx_data, 8'h00);
    chk("rst_ss_div1", bus1.ss, 1'b0);
    tick();
    reset = 1'b0;
    repeat (2) tick();

    // Loopback single byte
    miso_inv = 1'b0;
    drive_req(0, 1, 8'hA2, 8'h00, 8'h00);
    wait_idle();
    chk("ss_len_single", ss_last, 33);

    // Three-byte burst with inverted miso
    miso_inv = 1'b1;
    drive_req(0, 3, 8'h71, 8'h32, 8'hFF);
    wait_idle();
    chk("ss_len_burst", ss_last, 99);
    miso_inv = 1'b0;

    // Simultaneous requests straight out of reset
    reset = 1'b1;
    tick();
    reset = 1'b0;
    tick();
    base = gnt_log.size();
    fork
      drive_req(0, 1, 8'h11, 8'h00, 8'h00);
      drive_req(1, 1, 8'h22, 8'h00, 8'h00);
    join
    wait_idle();
    chk_grants("rr_reset", base);
    chk("gap_ss_low", lo_last, 3);

    base = gnt_log.size();
    fork
      drive_req(0, 1, 8'h33, 8'h00, 8'h00);
      drive_req(1, 1, 8'h44, 8'h00, 8'h00);
    join
    wait_idle();
    chk_grants("rr_repeat", base);

    // Requester 1 arrives mid-transfer of requester 0
    base = gnt_log.size();
    fork
      drive_req(0, 1, 8'h5C, 8'h00, 8'h00);
      begin
        repeat (12) tick();
        fork
          drive_req(1, 1, 8'hE7, 8'h00, 8'h00);
          begin
            repeat (5) tick();
            chk("gnt_mid_byte", bus2.gnt, 2'b01);
          end
        join
      end
    join
    wait_idle();
    chk_grants("late_req", base);

    // Reset during the 4th bit: no rx, clean restart
    set_tx(0, 8'hC3);
    set_req(0, 1'b1);
    wait_ack(0);
    tick();
    set_req(0, 1'b0);
    repeat (12) tick();
    chk("ss_before_rst", bus2.ss, 1'b1);
    rx_before = rx_seen;
    reset = 1'b1;
    #1;
    chk("midrst_ss", bus2.ss, 1'b0);
    chk("midrst_sclk", bus2.sclk, 1'b0);
    chk("midrst_mosi", bus2.mosi, 1'b0);
    chk("midrst_gnt", bus2.gnt, 2'b00);
    chk("midrst_rx_data", bus2.rx_data, 8'h00);
    repeat (2) tick();
    reset = 1'b0;
    repeat (40) tick();
    chk("midrst_no_rx", rx_seen, rx_before);
    drive_req(0, 1, 8'h3C, 8'h00, 8'h00);
    wait_idle();
    chk("ss_len_after_rst", ss_last, 33);

    // DIV=1 instance, miso tied high
    d1_tx = 8'h5A;
    d1_req = 1'b1;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus1.tx_ack[0] !== 1'b1 && t < 200);
    if (t >= 200) chk("d1_ack_timeout", bus1.tx_ack, 2'b01);
    tick();
    d1_req = 1'b0;
    t = 0;
    do begin
      @(negedge clk);
      t++;
    end while (bus1.rx_valid[0] !== 1'b1 && t < 200);
    chk("d1_rx_valid", bus1.rx_valid, 2'b01);
    chk("d1_rx_data", bus1.rx_data, 8'hFF);
    repeat (4) @(negedge clk);
    chk("d1_mosi_seq", mosi_seq, 8'h5A);
    chk("d1_sclk_rises", c1_rise, 8);
    chk("d1_sclk_pmin", c1_pmin, 2);
    chk("d1_sclk_pmax", c1_pmax, 2);
    chk("d1_ss_len", ss1_last, 17);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
